// File: rtl/rv32_ifetch_buffer.sv
// ---------------------------------------------------------------------------
// rv32_ifetch_buffer
//   Instruction-fetch unit for the RV32 core. Issues pipelined word reads on
//   the instruction bus, buffers returned words together with their PC in a
//   first-word-fall-through prefetch FIFO and hands them to decode over a
//   valid/ready handshake. A redirect flushes the FIFO and arranges for every
//   response still in flight (including a request held by iwaitrequest) to be
//   dropped.
//
// Parameters
//   RESET_VECTOR  first fetch address after reset
//   FIFO_DEPTH    prefetch entries (power of two, >= 2); also caps
//                 fifo_level + outstanding reads
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   iaddress, iread       bus read request (word-aligned address)
//   ireaddata             returned instruction word
//   iwaitrequest          bus stalls the presented request
//   ireaddatavalid        in-order read response strobe
//   redirect, redirect_pc one-cycle restart request and its target
//   instr_valid, instr,
//   instr_pc, instr_ready decode handshake (FIFO head)
//   fifo_level            entries currently held
// ---------------------------------------------------------------------------
module rv32_ifetch_buffer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic [31:0]                   iaddress,
  output logic                          iread,
  input  logic [31:0]                   ireaddata,
  input  logic                          iwaitrequest,
  input  logic                          ireaddatavalid,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  output logic                          instr_valid,
  output logic [31:0]                   instr,
  output logic [31:0]                   instr_pc,
  input  logic                          instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Architectural state
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_iaddress;
  logic          r_iread;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic          r_stale_req;

  // Prefetch FIFO
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [31:0]   r_mem_pc   [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_level;

  logic          w_accept;
  logic          w_hold;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_level_next;
  logic [CW-1:0] w_discard_next;
  logic          w_stale_next;
  logic [CW:0]   w_credit_sum;
  logic          w_unused_pc_lsb;

  assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  assign w_accept = r_iread && !iwaitrequest;
  assign w_hold   = r_iread &&  iwaitrequest;
  assign w_drop   = ireaddatavalid && (r_discard != '0);
  assign w_push   = ireaddatavalid && (r_discard == '0) && !redirect;
  assign w_pop    = (r_level != '0) && instr_ready && !redirect;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept)       w_out_next = w_out_next + ONE_C;
    if (ireaddatavalid) w_out_next = w_out_next - ONE_C;
  end

  always_comb begin
    w_level_next = r_level;
    if (redirect) begin
      w_level_next = '0;
    end else begin
      if (w_push) w_level_next = w_level_next + ONE_C;
      if (w_pop)  w_level_next = w_level_next - ONE_C;
    end
  end

  // A request accepted while stale_req is set was aimed at the pre-redirect
  // stream: it neither advances fetch_pc nor survives, so it is added to the
  // discard count at acceptance time.
  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    w_discard_next  = r_discard;
    w_stale_next    = r_stale_req;
    if (redirect) begin
      w_fetch_pc_next = w_redirect_pc;
      w_discard_next  = w_out_next;
    end else begin
      if (w_accept && !r_stale_req) w_fetch_pc_next = r_fetch_pc + 32'd4;
      if (w_drop)                   w_discard_next  = w_discard_next - ONE_C;
      if (w_accept && r_stale_req)  w_discard_next  = w_discard_next + ONE_C;
    end
    if (w_accept)                 w_stale_next = 1'b0;
    else if (redirect && w_hold)  w_stale_next = 1'b1;
  end

  // Credit is judged on post-cycle values so back-to-back issue never lets
  // buffered + in-flight words exceed the FIFO capacity.
  assign w_credit_sum = {1'b0, w_level_next} + {1'b0, w_out_next};
  assign w_issue      = !w_hold && !redirect && (w_credit_sum < {1'b0, DEPTH_C});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_resp_pc     <= RESET_VECTOR;
      r_iaddress    <= RESET_VECTOR;
      r_iread       <= 1'b0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_stale_req   <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_next;
      r_outstanding <= w_out_next;
      r_discard     <= w_discard_next;
      r_stale_req   <= w_stale_next;
      r_level       <= w_level_next;

      if (redirect) begin
        r_resp_pc <= w_redirect_pc;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
      end else begin
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      // A stalled request keeps iread/iaddress untouched, even across redirect.
      if (w_hold) begin
        r_iread    <= 1'b1;
        r_iaddress <= r_iaddress;
      end else if (w_issue) begin
        r_iread    <= 1'b1;
        r_iaddress <= w_fetch_pc_next;
      end else begin
        r_iread    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= ireaddata;
      r_mem_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  assign iread       = r_iread;
  assign iaddress    = r_iaddress;
  assign fifo_level  = r_level;
  assign instr_valid = (r_level != '0);
  assign instr       = instr_valid ? r_mem_data[r_rd_ptr] : '0;
  assign instr_pc    = instr_valid ? r_mem_pc[r_rd_ptr]   : '0;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    w_push |-> (r_level < DEPTH_C));
  a_outstanding_cap: assert property (@(posedge clk) disable iff (!reset_n)
    r_outstanding <= DEPTH_C);

endmodule

// File: tb/tb_rv32_ifetch_buffer.sv
`timescale 1ns/1ps
module tb_rv32_ifetch_buffer;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 4;
  localparam int          LW    = $clog2(DEPTH) + 1;

  logic          clk            = 1'b0;
  logic          reset_n        = 1'b0;
  logic [31:0]   iaddress;
  logic          iread;
  logic [31:0]   ireaddata      = '0;
  logic          iwaitrequest   = 1'b0;
  logic          ireaddatavalid = 1'b0;
  logic          redirect       = 1'b0;
  logic [31:0]   redirect_pc    = '0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready    = 1'b0;
  logic [LW-1:0] fifo_level;

  rv32_ifetch_buffer #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .iaddress       (iaddress),
    .iread          (iread),
    .ireaddata      (ireaddata),
    .iwaitrequest   (iwaitrequest),
    .ireaddatavalid (ireaddatavalid),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        bus_q[$];     // accepted reads awaiting a response
  exp_t        exp_q[$];     // expected instruction stream (scoreboard)
  logic [31:0] acc_log[$];   // accepted addresses since last reset

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int acc_count = 0;
  int pop_count = 0;
  int tb_out    = 0;
  int lat_max   = 1;
  logic [31:0] gen_pc = RV;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: bus acceptance bookkeeping plus decode-side scoreboard compare.
  initial begin : monitor
    logic        prev_hold;
    logic        redir_prev;
    logic [31:0] prev_addr;
    exp_t        e;
    prev_hold  = 1'b0;
    redir_prev = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hold  = 1'b0;
        redir_prev = 1'b0;
        tb_out     = 0;
        acc_count  = 0;
        acc_log.delete();
      end else begin
        if (prev_hold) begin
          check("held_iread", 32'(iread), 32'd1);
          check("held_iaddress", iaddress, prev_addr);
        end
        if (iread) check("iaddress_align", {30'd0, iaddress[1:0]}, 32'd0);
        prev_hold = iread && iwaitrequest;
        prev_addr = iaddress;
        if (iread && !iwaitrequest) begin
          bus_q.push_back('{addr: iaddress, due: cyc + int'($urandom_range(1, lat_max))});
          acc_log.push_back(iaddress);
          acc_count++;
          tb_out++;
        end
        if (ireaddatavalid) tb_out--;
        check("outstanding_cap", 32'(tb_out <= DEPTH), 32'd1);
        check("valid_vs_level", 32'(instr_valid), 32'(fifo_level != '0));
        if (redir_prev) check("valid_after_redirect", 32'(instr_valid), 32'd0);
        redir_prev = redirect;
        if (!redirect && instr_valid && instr_ready) begin
          pop_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: popped pc %h, nothing expected", instr_pc);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input int vpct);
    if (bus_q.size() > 0 && bus_q[0].due <= cyc && int'($urandom_range(0, 99)) < vpct) begin
      ireaddatavalid = 1'b1;
      ireaddata      = mem_word(bus_q[0].addr);
      bus_q.delete(0);
    end else begin
      ireaddatavalid = 1'b0;
      ireaddata      = $urandom;
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: gen_pc, data: mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    exp_q.delete();
    gen_pc      = {t[31:2], 2'b00};
  endtask

  task automatic do_reset(input int n);
    reset_n        = 1'b0;
    redirect       = 1'b0;
    iwaitrequest   = 1'b0;
    ireaddatavalid = 1'b0;
    bus_q.delete();
    exp_q.delete();
    gen_pc = RV;
    refill();
    #1;
    check("rst_iread", 32'(iread), 32'd0);
    check("rst_iaddress", iaddress, RV);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r;
      1:       return 32'hFFFF_FFF0 + (r & 32'h0000_000F);
      2:       return 32'h0000_0100;
      default: return 32'h0000_0200 | (r & 32'h0000_0003);
    endcase
  endfunction

  initial begin : stimulus
    int  p0, p1, n12, after12;
    logic found;
    p0 = 0; p1 = 0; n12 = 0; after12 = 0; found = 1'b0;

    // Reset state
    repeat (2) step();
    do_reset(2);

    // Zero-wait bus, 1-cycle latency, decoder always ready: 1 instr/cycle
    instr_ready = 1'b1;
    lat_max     = 1;
    for (int k = 0; k < 31; k++) begin
      step();
      redirect = 1'b0; iwaitrequest = 1'b0;
      drive_bus(100);
      refill();
      if (k == 10) p0 = pop_count;
      if (k == 30) p1 = pop_count;
    end
    check("b_throughput", 32'(p1 - p0), 32'd20);
    for (int i = 0; i < 4; i++) check("b_iaddress_seq", acc_log[i], RV + 32'(4 * i));

    // Decoder stalled: credit limits reads to FIFO_DEPTH
    step();
    instr_ready = 1'b0;
    do_reset(2);
    for (int k = 0; k < 20; k++) begin
      step();
      redirect = 1'b0; iwaitrequest = 1'b0;
      drive_bus(100);
      refill();
    end
    check("c_accepts", 32'(acc_count), 32'd4);
    check("c_fifo_level", 32'(fifo_level), 32'd4);
    check("c_iread_low", 32'(iread), 32'd0);
    check("c_head_pc", instr_pc, RV);
    instr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      drive_bus(100);
      refill();
    end
    check("c_resume_addr", acc_log[4], RV + 32'd16);

    // Redirect to 0x200 while the read of 12 is held by iwaitrequest
    step();
    do_reset(2);
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      redirect = 1'b0; iwaitrequest = 1'b0;
      drive_bus(100);
      if (iread && iaddress == RV + 32'd12) begin
        found        = 1'b1;
        iwaitrequest = 1'b1;
        do_redirect(32'h0000_0200);
      end
      refill();
    end
    check("e_reached_12", 32'(found), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step();
      redirect = 1'b0; iwaitrequest = 1'b1;
      drive_bus(100);
      refill();
    end
    for (int k = 0; k < 20; k++) begin
      step();
      redirect = 1'b0; iwaitrequest = 1'b0;
      drive_bus(100);
      refill();
    end
    foreach (acc_log[i]) begin
      if (acc_log[i] == RV + 32'd12) begin
        n12++;
        if (i + 1 < acc_log.size()) after12 = int'(acc_log[i + 1]);
      end
    end
    check("e_addr12_once", 32'(n12), 32'd1);
    check("e_next_after_12", 32'(after12), 32'h0000_0200);

    // Randomized traffic with redirects, stalls, latency and a mid-burst reset
    lat_max = 3;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (k == 1200) begin
        do_reset(2);
        continue;
      end
      iwaitrequest = ($urandom_range(0, 99) < 30);
      instr_ready  = ($urandom_range(0, 99) < 70);
      drive_bus(80);
      if (!redirect && ((iread && iwaitrequest && $urandom_range(0, 99) < 20) ||
                        (ireaddatavalid && $urandom_range(0, 99) < 8) ||
                        ($urandom_range(0, 99) < 3)))
        do_redirect(pick_target());
      else
        redirect = 1'b0;
      refill();
    end

    // Drain
    for (int k = 0; k < 40; k++) begin
      step();
      redirect = 1'b0; iwaitrequest = 1'b0; instr_ready = 1'b1;
      drive_bus(100);
      refill();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rv32_ifetch_buffer.md
Name: rv32_ifetch_buffer

Overview:
- Parametrised instruction-fetch unit with prefetch FIFO, sitting between the instruction bus and the decoder of the RV32 core.
- Issues pipelined reads, honours iwaitrequest and buffers returned words tagged with their PC.
- Presents instructions to decode over a valid/ready handshake, so a decoder stall applies backpressure.
- On a PC redirect (branch, jump or trap), flushes the buffer and discards in-flight responses.

Parameters:
RESET_VECTOR, 32'h00000000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2; also the cap on fifo_count + outstanding reads

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
iaddress  output  32  instruction bus address, word aligned
iread  output  1  instruction bus read request
ireaddata  input  32  returned instruction word
iwaitrequest  input  1  bus not accepting request this cycle
ireaddatavalid  input  1  ireaddata valid (in-order responses)
redirect  input  1  single-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  32  new fetch address (bits [1:0] ignored, forced 0)
instr_valid  output  1  FIFO head valid
instr  output  32  FIFO head instruction
instr_pc  output  32  PC of FIFO head
instr_ready  input  1  decoder accepts head this cycle
fifo_level  output  clog2(FIFO_DEPTH)+1  entries currently held

Behaviour:
- Reset (asynchronous, reset_n low):
  - fetch_pc = RESET_VECTOR, resp_pc = RESET_VECTOR, iaddress = RESET_VECTOR.
  - iread = 0, FIFO empty, outstanding = 0, discard = 0, stale_req = 0.
  - instr_valid = 0, instr = 0, instr_pc = 0, fifo_level = 0.
- Reset released mid-transfer: all in-flight state is lost. The bench must not return data for pre-reset requests.
- Issue:
  - iread rises when not holding a request, redirect = 0, and fifo_level + outstanding < FIFO_DEPTH. iaddress = fetch_pc at that point.
  - While iread && iwaitrequest, iread and iaddress are held stable (including across redirect).
  - Acceptance = iread && !iwaitrequest. On acceptance: outstanding += 1; fetch_pc += 4 unless stale_req. iread may stay high next cycle for back-to-back issue if credit remains.
  - Maximum throughput is 1 word per cycle.
- Response:
  - On ireaddatavalid, outstanding -= 1.
  - If discard > 0: discard -= 1 and the word is dropped.
  - Otherwise push {resp_pc, ireaddata} and resp_pc += 4.
- Output:
  - FIFO is first-word-fall-through: instr_valid = (fifo_level != 0); instr and instr_pc show the head.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle leaves level unchanged. Push into a full FIFO cannot occur by the credit rule; an assertion checks it.
- Redirect (cycle N):
  - FIFO cleared at end of N, so instr_valid = 0 at N+1. A pop or a response in cycle N is discarded.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding value after cycle N, including a request accepted in N.
  - If a request is held by iwaitrequest at N: stale_req = 1. When accepted: discard += 1, outstanding += 1, fetch_pc unchanged, stale_req = 0.
  - No new issue in cycle N; the first issue to redirect_pc occurs at N+1 at the earliest.
  - Redirect while discard > 0 re-computes discard as above (cumulative, no loss).
- Wrap-around: fetch_pc and resp_pc wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- Counters are sized clog2(FIFO_DEPTH)+1. outstanding never exceeds FIFO_DEPTH.

Test Plan:
- Zero-wait bus, 1-cycle read latency, instr_ready = 1 after reset -> iaddress sequence 0,4,8,12; instr_pc matches each instr; sustained 1 instr/cycle.
- instr_ready = 0, FIFO_DEPTH = 4 -> exactly 4 reads accepted, iread low, fifo_level = 4; raise ready -> pops 0,4,8,12 in order, fetch resumes at 16.
- iwaitrequest high 3 cycles on address 8 -> iread and iaddress held at 8 for 4 cycles; single acceptance; no duplicate entry.
- 2 reads outstanding, redirect to 32'h100 -> both responses dropped, instr_valid low until first instr_pc = 32'h100 appears.
- Redirect to 32'h200 while address 12 is held by iwaitrequest -> 12 issued once and dropped; next issued address 32'h200; no entry with pc 12.
- Redirect with ireaddatavalid in the same cycle; reset_n pulsed mid-burst -> response dropped; after reset, iaddress = RESET_VECTOR, level = 0.
